// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer and its CDB/arch-state neighbours.
package reorder_buffer_pkg;

  localparam int unsigned NUM_FU       = 2;
  localparam int unsigned NUM_PHYS_REG = 128;
  localparam int unsigned NUM_FLAGS    = 4;
  localparam int unsigned WORD_SIZE_P  = 32;
  localparam int unsigned ROB_DEPTH    = 16;

  localparam int unsigned PR_W      = $clog2(NUM_PHYS_REG);
  localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);

  // Common data bus broadcast from one functional unit.
  typedef struct packed {
    logic                   valid;
    logic [PR_W-1:0]        dest;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;

  // One in-flight instruction awaiting in-order commit.
  typedef struct packed {
    logic                 valid;
    logic                 has_dest;
    logic [PR_W-1:0]      dest;
    logic [PR_W-1:0]      old_dest;
    logic                 is_branch;
    logic [NUM_FLAGS-1:0] flag_mask;
    logic [NUM_FLAGS-1:0] flags;
    logic                 dest_done;
    logic                 res_done;
    logic                 mispredict;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit buffer: entries complete out of order, the head retires at
// most once per cycle and drives registered commit pulses to arch_state.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int unsigned ROB_DEPTH    = reorder_buffer_pkg::ROB_DEPTH,
  parameter  int unsigned NUM_FU       = reorder_buffer_pkg::NUM_FU,
  parameter  int unsigned NUM_PHYS_REG = reorder_buffer_pkg::NUM_PHYS_REG,
  parameter  int unsigned NUM_FLAGS    = reorder_buffer_pkg::NUM_FLAGS,
  localparam int unsigned PR_W         = $clog2(NUM_PHYS_REG),
  localparam int unsigned IDX_W        = $clog2(ROB_DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   disp_valid_i,
  output logic                   disp_ready_o,
  input  logic                   disp_has_dest_i,
  input  logic [PR_W-1:0]        disp_dest_i,
  input  logic [PR_W-1:0]        disp_old_dest_i,
  input  logic                   disp_is_branch_i,
  input  logic [NUM_FLAGS-1:0]   disp_flag_mask_i,
  output logic [IDX_W-1:0]       disp_rob_idx_o,
  input  CDB_t                   cdb_i [NUM_FU],
  input  logic                   res_valid_i,
  input  logic [IDX_W-1:0]       res_rob_idx_i,
  input  logic [NUM_FLAGS-1:0]   res_flags_i,
  input  logic                   res_mispredict_i,
  output logic                   rob_phys_valid_o,
  output logic [PR_W-1:0]        rob_phys_reg_cl_o,
  output logic [PR_W-1:0]        rob_phys_reg_set_o,
  output logic                   rob_phys_mispredict_o,
  output logic                   rob_flag_valid_o,
  output logic [2*NUM_FLAGS-1:0] rob_flag_o,
  output logic [IDX_W:0]         rob_count_o
);

  logic [IDX_W:0]         head_q, head_d, tail_q, tail_d;
  rob_entry_t             entries_q [ROB_DEPTH];
  rob_entry_t             entries_d [ROB_DEPTH];

  logic                   phys_valid_q, phys_valid_d;
  logic [PR_W-1:0]        reg_cl_q, reg_cl_d;
  logic [PR_W-1:0]        reg_set_q, reg_set_d;
  logic                   mispredict_q, mispredict_d;
  logic                   flag_valid_q, flag_valid_d;
  logic [2*NUM_FLAGS-1:0] flag_q, flag_d;

  logic [IDX_W-1:0]       head_idx, tail_idx;
  rob_entry_t             head_e;
  logic                   full, retire, flush, disp_fire;
  logic                   cdb_result_unused;

  // Occupancy, head readiness and dispatch handshake from the current state.
  always_comb begin
    head_idx       = head_q[IDX_W-1:0];
    tail_idx       = tail_q[IDX_W-1:0];
    head_e         = entries_q[head_idx];
    full           = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    retire         = head_e.valid && head_e.dest_done && head_e.res_done;
    flush          = retire && head_e.mispredict;
    disp_ready_o   = !full && !flush && !mispredict_q && !reset_i;
    disp_fire      = disp_valid_i && disp_ready_o;
    rob_count_o    = tail_q - head_q;
    disp_rob_idx_o = tail_idx;
  end

  // Entry updates: completions first, then retire/flush, then the new tail entry.
  // Readiness is judged on entries_q, so a same-cycle completion retires next cycle.
  always_comb begin
    entries_d = entries_q;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (cdb_i[f].valid && entries_q[i].valid && entries_q[i].has_dest &&
            !entries_q[i].dest_done && (entries_q[i].dest == cdb_i[f].dest)) begin
          entries_d[i].dest_done = 1'b1;
        end
      end
    end
    if (res_valid_i && entries_q[res_rob_idx_i].valid) begin
      entries_d[res_rob_idx_i].res_done   = 1'b1;
      entries_d[res_rob_idx_i].flags      = res_flags_i;
      entries_d[res_rob_idx_i].mispredict = res_mispredict_i && entries_q[res_rob_idx_i].is_branch;
    end
    if (retire) begin
      entries_d[head_idx].valid = 1'b0;
    end
    if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end
    if (disp_fire) begin
      entries_d[tail_idx] = '{
        valid:      1'b1,
        has_dest:   disp_has_dest_i,
        dest:       disp_dest_i,
        old_dest:   disp_old_dest_i,
        is_branch:  disp_is_branch_i,
        flag_mask:  disp_flag_mask_i,
        flags:      '0,
        dest_done:  !disp_has_dest_i,
        res_done:   !(disp_is_branch_i || (|disp_flag_mask_i)),
        mispredict: 1'b0
      };
    end
  end

  // Pointer advance; a mispredict flush collapses head onto tail.
  always_comb begin
    tail_d = tail_q + {{IDX_W{1'b0}}, disp_fire};
    head_d = flush ? tail_q : head_q + {{IDX_W{1'b0}}, retire};
  end

  // Commit outputs are single-cycle pulses of the retiring head's fields.
  always_comb begin
    phys_valid_d = 1'b0;
    reg_cl_d     = '0;
    reg_set_d    = '0;
    mispredict_d = 1'b0;
    flag_valid_d = 1'b0;
    flag_d       = '0;
    if (retire) begin
      phys_valid_d = head_e.has_dest;
      reg_cl_d     = head_e.old_dest;
      reg_set_d    = head_e.dest;
      mispredict_d = head_e.mispredict;
      flag_valid_d = |head_e.flag_mask;
      flag_d       = {head_e.flag_mask, head_e.flags};
    end
  end

  // CDB result data is carried for other consumers; only tags matter here.
  always_comb begin
    cdb_result_unused = 1'b0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      cdb_result_unused = cdb_result_unused ^ (^cdb_i[f].result);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      phys_valid_q <= 1'b0;
      reg_cl_q     <= '0;
      reg_set_q    <= '0;
      mispredict_q <= 1'b0;
      flag_valid_q <= 1'b0;
      flag_q       <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      entries_q    <= entries_d;
      phys_valid_q <= phys_valid_d;
      reg_cl_q     <= reg_cl_d;
      reg_set_q    <= reg_set_d;
      mispredict_q <= mispredict_d;
      flag_valid_q <= flag_valid_d;
      flag_q       <= flag_d;
    end
  end

  assign rob_phys_valid_o      = phys_valid_q;
  assign rob_phys_reg_cl_o     = reg_cl_q;
  assign rob_phys_reg_set_o    = reg_set_q;
  assign rob_phys_mispredict_o = mispredict_q;
  assign rob_flag_valid_o      = flag_valid_q;
  assign rob_flag_o            = flag_q;

  // A branch never writes a physical register.
  illegal_branch_dest_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (disp_valid_i && disp_ready_o) |-> !(disp_is_branch_i && disp_has_dest_i));

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based model.
`timescale 1ns/1ps
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = $clog2(128);
  localparam int NF    = 4;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic            disp_valid_i, disp_ready_o, disp_has_dest_i, disp_is_branch_i;
  logic [PW-1:0]   disp_dest_i, disp_old_dest_i;
  logic [NF-1:0]   disp_flag_mask_i;
  logic [IW-1:0]   disp_rob_idx_o;
  CDB_t            cdb_i [NUM_FU];
  logic            res_valid_i, res_mispredict_i;
  logic [IW-1:0]   res_rob_idx_i;
  logic [NF-1:0]   res_flags_i;
  logic            rob_phys_valid_o, rob_phys_mispredict_o, rob_flag_valid_o;
  logic [PW-1:0]   rob_phys_reg_cl_o, rob_phys_reg_set_o;
  logic [2*NF-1:0] rob_flag_o;
  logic [IW:0]     rob_count_o;

  reorder_buffer #(
    .ROB_DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_PHYS_REG(128), .NUM_FLAGS(NF)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_has_dest_i(disp_has_dest_i), .disp_dest_i(disp_dest_i),
    .disp_old_dest_i(disp_old_dest_i), .disp_is_branch_i(disp_is_branch_i),
    .disp_flag_mask_i(disp_flag_mask_i), .disp_rob_idx_o(disp_rob_idx_o),
    .cdb_i(cdb_i),
    .res_valid_i(res_valid_i), .res_rob_idx_i(res_rob_idx_i),
    .res_flags_i(res_flags_i), .res_mispredict_i(res_mispredict_i),
    .rob_phys_valid_o(rob_phys_valid_o), .rob_phys_reg_cl_o(rob_phys_reg_cl_o),
    .rob_phys_reg_set_o(rob_phys_reg_set_o), .rob_phys_mispredict_o(rob_phys_mispredict_o),
    .rob_flag_valid_o(rob_flag_valid_o), .rob_flag_o(rob_flag_o),
    .rob_count_o(rob_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int idx; bit has; int dest; int old; bit br; int mask; int flags; bit dd; bit rd; bit mp;
  } ment_t;
  ment_t mq[$];
  int    m_tail;
  bit    e_pv, e_mp, e_fv;
  int    e_cl, e_set, e_flag;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_pv = 0; e_mp = 0; e_fv = 0; e_cl = 0; e_set = 0; e_flag = 0;
  endtask

  function automatic bit m_head_ready();
    return (mq.size() > 0) && mq[0].dd && mq[0].rd;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !(m_head_ready() && mq[0].mp) && !e_mp;
  endfunction

  task automatic check_all();
    check_eq("count", 32'(rob_count_o), mq.size());
    check_eq("ready", 32'(disp_ready_o), 32'(m_ready()));
    check_eq("idx", 32'(disp_rob_idx_o), m_tail);
    check_eq("phys_valid", 32'(rob_phys_valid_o), 32'(e_pv));
    check_eq("mispredict", 32'(rob_phys_mispredict_o), 32'(e_mp));
    check_eq("flag_valid", 32'(rob_flag_valid_o), 32'(e_fv));
    if (e_pv) begin
      check_eq("reg_cl", 32'(rob_phys_reg_cl_o), e_cl);
      check_eq("reg_set", 32'(rob_phys_reg_set_o), e_set);
    end
    if (e_fv) check_eq("flag", 32'(rob_flag_o), e_flag);
  endtask

  task automatic idle();
    disp_valid_i = 0; disp_has_dest_i = 0; disp_dest_i = '0; disp_old_dest_i = '0;
    disp_is_branch_i = 0; disp_flag_mask_i = '0;
    for (int f = 0; f < NUM_FU; f++) cdb_i[f] = '0;
    res_valid_i = 0; res_rob_idx_i = '0; res_flags_i = '0; res_mispredict_i = 0;
  endtask

  task automatic disp(input bit has, input int dest, input int old, input bit br, input int mask);
    disp_valid_i = 1; disp_has_dest_i = has; disp_dest_i = PW'(dest);
    disp_old_dest_i = PW'(old); disp_is_branch_i = br; disp_flag_mask_i = NF'(mask);
  endtask

  task automatic cdb_set(input int lane, input int dest);
    cdb_i[lane] = '{valid: 1'b1, dest: PW'(dest), result: $urandom};
  endtask

  task automatic res_set(input int idx, input int flags, input bit mp);
    res_valid_i = 1; res_rob_idx_i = IW'(idx); res_flags_i = NF'(flags); res_mispredict_i = mp;
  endtask

  // Advance model and DUT one clock, then compare at the falling edge.
  task automatic tick();
    bit acc, ret;
    ment_t h, n, t;
    acc = disp_valid_i && m_ready();
    ret = m_head_ready();
    if (ret) h = mq[0];
    for (int f = 0; f < NUM_FU; f++) begin
      if (cdb_i[f].valid) begin
        for (int k = 0; k < mq.size(); k++) begin
          t = mq[k];
          if (t.has && !t.dd && t.dest == int'(cdb_i[f].dest)) begin
            t.dd = 1; mq[k] = t;
          end
        end
      end
    end
    if (res_valid_i) begin
      for (int k = 0; k < mq.size(); k++) begin
        t = mq[k];
        if (t.idx == int'(res_rob_idx_i)) begin
          t.rd = 1; t.flags = int'(res_flags_i); t.mp = res_mispredict_i && t.br; mq[k] = t;
        end
      end
    end
    e_pv = 0; e_mp = 0; e_fv = 0; e_cl = 0; e_set = 0; e_flag = 0;
    if (ret) begin
      e_pv = h.has; e_cl = h.old; e_set = h.dest; e_fv = (h.mask != 0);
      e_flag = h.mask * 16 + h.flags; e_mp = h.mp;
      void'(mq.pop_front());
      if (h.mp) mq.delete();
    end
    if (acc) begin
      n.idx = m_tail; n.has = disp_has_dest_i; n.dest = int'(disp_dest_i);
      n.old = int'(disp_old_dest_i); n.br = disp_is_branch_i; n.mask = int'(disp_flag_mask_i);
      n.flags = 0; n.dd = !disp_has_dest_i; n.rd = !(disp_is_branch_i || (disp_flag_mask_i != 0));
      n.mp = 0;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic do_reset();
    reset_i = 1;
    idle();
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bidx, fidx, k;
    bit br, has;
    idle();
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("rst_ready", 32'(disp_ready_o), 0);
    check_eq("rst_count", 32'(rob_count_o), 0);
    check_eq("rst_pv", 32'(rob_phys_valid_o), 0);
    check_eq("rst_mp", 32'(rob_phys_mispredict_o), 0);
    check_eq("rst_fv", 32'(rob_flag_valid_o), 0);
    reset_i = 0;
    #1;
    check_eq("ready_after_rst", 32'(disp_ready_o), 1);

    // Single dispatch then CDB completion.
    check_eq("t1_idx", 32'(disp_rob_idx_o), 0);
    disp(1, 20, 5, 0, 0); tick();
    idle(); tick();
    cdb_set(0, 20); tick();
    idle(); tick();
    check_eq("t1_pv", 32'(rob_phys_valid_o), 1);
    check_eq("t1_cl", 32'(rob_phys_reg_cl_o), 5);
    check_eq("t1_set", 32'(rob_phys_reg_set_o), 20);
    check_eq("t1_count", 32'(rob_count_o), 0);
    tick();
    check_eq("t1_pulse_end", 32'(rob_phys_valid_o), 0);

    // Out-of-order completion, in-order back-to-back commit.
    for (int i = 0; i < 3; i++) begin disp(1, 30 + i, 1 + i, 0, 0); tick(); end
    idle();
    for (int i = 2; i >= 0; i--) begin idle(); cdb_set(1, 30 + i); tick(); end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_pv", 32'(rob_phys_valid_o), 1);
      check_eq("t2_set", 32'(rob_phys_reg_set_o), 30 + i);
    end

    // Full buffer.
    for (int i = 0; i < DEPTH; i++) begin disp(1, 40 + i, i, 0, 0); tick(); end
    idle();
    check_eq("t3_full_count", 32'(rob_count_o), 16);
    check_eq("t3_full_ready", 32'(disp_ready_o), 0);
    cdb_set(0, 40); tick();
    idle();
    check_eq("t3_full_retiring_ready", 32'(disp_ready_o), 0);
    tick();
    check_eq("t3_after_retire_ready", 32'(disp_ready_o), 1);
    check_eq("t3_after_retire_count", 32'(rob_count_o), 15);
    for (int i = 1; i < DEPTH; i++) begin idle(); cdb_set(0, 40 + i); tick(); end
    idle(); tick(); tick();
    check_eq("t3_drained", 32'(rob_count_o), 0);

    // Flag write.
    fidx = m_tail;
    disp(0, 0, 0, 0, 4'b0101); tick();
    idle(); res_set(fidx, 4'b1111, 0); tick();
    idle(); tick();
    check_eq("t4_fv", 32'(rob_flag_valid_o), 1);
    check_eq("t4_flag", 32'(rob_flag_o), 8'b0101_1111);

    // Mispredict rollback.
    idle(); tick();
    bidx = m_tail;
    disp(0, 0, 0, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin disp(1, 70 + i, 10 + i, 0, 0); tick(); end
    idle(); res_set(bidx, 0, 1); tick();
    idle();
    check_eq("t5_retire_ready", 32'(disp_ready_o), 0);
    disp(1, 80, 1, 0, 0); tick();
    check_eq("t5_mp_pulse", 32'(rob_phys_mispredict_o), 1);
    check_eq("t5_pv", 32'(rob_phys_valid_o), 0);
    check_eq("t5_count", 32'(rob_count_o), 0);
    check_eq("t5_pulse_ready", 32'(disp_ready_o), 0);
    tick();
    check_eq("t5_mp_end", 32'(rob_phys_mispredict_o), 0);
    check_eq("t5_not_accepted", 32'(rob_count_o), 0);
    idle();

    // Wrap-around then asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      idle();
      check_eq("t6_wrap_idx", 32'(disp_rob_idx_o), i % DEPTH);
      disp(1, 60 + i, i, 0, 0);
      if (i > 0) cdb_set(0, 59 + i);
      tick();
    end
    idle(); cdb_set(0, 99); tick();
    idle();
    check_eq("t6_pv_before_rst", 32'(rob_phys_valid_o), 1);
    #2;
    reset_i = 1;
    #1;
    check_eq("t6_rst_pv", 32'(rob_phys_valid_o), 0);
    check_eq("t6_rst_set", 32'(rob_phys_reg_set_o), 0);
    check_eq("t6_rst_cl", 32'(rob_phys_reg_cl_o), 0);
    check_eq("t6_rst_mp", 32'(rob_phys_mispredict_o), 0);
    check_eq("t6_rst_fv", 32'(rob_flag_valid_o), 0);
    check_eq("t6_rst_flag", 32'(rob_flag_o), 0);
    check_eq("t6_rst_count", 32'(rob_count_o), 0);
    check_eq("t6_rst_ready", 32'(disp_ready_o), 0);
    check_eq("t6_rst_idx", 32'(disp_rob_idx_o), 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 0;
    #1;
    check_all();

    // Randomized traffic.
    repeat (3000) begin
      idle();
      if ($urandom_range(0, 9) < 6) begin
        br  = ($urandom_range(0, 5) == 0);
        has = br ? 1'b0 : ($urandom_range(0, 3) != 0);
        disp(has, $urandom_range(1, 127), $urandom_range(0, 127), br,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0);
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, mq.size() - 1);
          cdb_set(f, mq[k].dest);
        end else if ($urandom_range(0, 7) == 0) begin
          cdb_set(f, $urandom_range(0, 127));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
          k = $urandom_range(0, mq.size() - 1);
          res_set(mq[k].idx, $urandom_range(0, 15), $urandom_range(0, 3) == 0);
        end else begin
          res_set($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), $urandom_range(0, 1));
        end
      end
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
